sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/tl_pkg.sv | 25 ++
 rtl/lane_debounce.sv | 71 +++++++
 rtl/sensor_conditioner.sv | 83 ++++++++
 tb/tb_sensor_conditioner.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared constants for the traffic-light subsystem: lane count, default
// sensor-conditioning parameters and the symbolic approach indices T1..T4.
// No ports; imported by sensor_conditioner and lane_debounce.
// -----------------------------------------------------------------------------
package tl_pkg;

    localparam int NUM_LANES = 4;

    // Defaults for the sensor conditioner parameters
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_FULL_THRESH     = 8;
    localparam int DEF_CNT_W           = 4;

    // Approach indices; bit position of each approach in lane-wide vectors
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;

    // One bit per approach
    typedef logic [NUM_LANES-1:0] lane_mask_t;

endpackage

// File: rtl/lane_debounce.sv
// -----------------------------------------------------------------------------
// lane_debounce
// One detector lane: 2-flop synchronizer, counter-based debounce and a
// single-cycle rise pulse on every 0->1 change of the debounced level.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   raw asynchronous detector level
//   rise   out  high for the one cycle after the debounced level goes 0->1
// -----------------------------------------------------------------------------
module lane_debounce
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    // DEBOUNCE_CYCLES never exceeds 15, so four bits always hold the count
    localparam logic [3:0] LAST_COUNT = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync_a;
    logic       sync_b;
    logic       level;
    logic       level_d;
    logic [3:0] deb_cnt;

    // Two-flop synchronizer; sync_b is the only version of raw used below
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // The counter tracks consecutive cycles of disagreement with the accepted
    // level; any agreeing cycle restarts it, so shorter glitches never flip it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= 1'b0;
            deb_cnt <= 4'd0;
        end else if (sync_b == level) begin
            deb_cnt <= 4'd0;
        end else if (deb_cnt == LAST_COUNT) begin
            level   <= ~level;
            deb_cnt <= 4'd0;
        end else begin
            deb_cnt <= deb_cnt + 4'd1;
        end
    end

    // Delayed copy of the level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // Combinational so the queue counter sees the event on the very next edge
    assign rise = level & ~level_d;

endmodule

// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
// Turns four raw vehicle-detector inputs into per-lane queue counts and the
// waiting / queue-full flags consumed by the traffic light controller.
// Each debounced arrival bumps the lane's saturating counter; a green lamp on
// a lane empties that lane's queue and overrides any simultaneous arrival.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   raw_det  in   [3:0] raw detector levels, bit 0 = T1
//   green    in   [3:0] green lamps fed back from the controller
//   ss       out  [3:0] vehicle waiting (queue count non-zero)
//   fs       out  [3:0] queue full (count at or above FULL_THRESH)
//   q_cnt    out  [4*CNT_W-1:0] queue counts, lane i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module sensor_conditioner
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FULL_THRESH     = DEF_FULL_THRESH,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_LANES-1:0]       raw_det,
    input  logic [NUM_LANES-1:0]       green,
    output logic [NUM_LANES-1:0]       ss,
    output logic [NUM_LANES-1:0]       fs,
    output logic [NUM_LANES*CNT_W-1:0] q_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FULL_THRESH);

    lane_mask_t               arrival;
    logic [NUM_LANES*CNT_W-1:0] q_next;
    lane_mask_t               ss_next;
    lane_mask_t               fs_next;

    // One independent conditioning chain per approach
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_det[i]),
            .rise (arrival[i])
        );
    end

    // Next counts and flags are derived together so the registered flags
    // always describe the registered counts; green wins over an arrival.
    always_comb begin
        q_next  = q_cnt;
        ss_next = '0;
        fs_next = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (green[i]) begin
                q_next[i*CNT_W +: CNT_W] = '0;
            end else if (arrival[i] && (q_cnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                q_next[i*CNT_W +: CNT_W] = q_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
            ss_next[i] = (q_next[i*CNT_W +: CNT_W] != '0);
            fs_next[i] = (q_next[i*CNT_W +: CNT_W] >= FULL_LVL);
        end
    end

    // Queue counters and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cnt <= '0;
            ss    <= '0;
            fs    <= '0;
        end else begin
            q_cnt <= q_next;
            ss    <= ss_next;
            fs    <= fs_next;
        end
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sensor_conditioner
// Self-checking bench for sensor_conditioner with default parameters.
// Expected values come from constant tables, closed-form pulse arithmetic and
// a queue-based behavioural model of the detector conditioning.
// -----------------------------------------------------------------------------
module tb_sensor_conditioner;
    import tl_pkg::*;

    localparam int DEB  = 4;
    localparam int FULL = 8;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  raw_det = 4'b0;
    logic [3:0]  green = 4'b0;
    logic [3:0]  ss;
    logic [3:0]  fs;
    logic [15:0] q_cnt;

    int checks = 0;
    int failures = 0;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .FULL_THRESH    (FULL),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_det(raw_det),
        .green  (green),
        .ss     (ss),
        .fs     (fs),
        .q_cnt  (q_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples age two edges through rawQ, the last DEB
    // synchronized samples sit in synQ, and a lane's level flips once all of
    // them disagree with it. A rise is counted on the following edge.
    logic [3:0] rawQ[$];
    logic [3:0] synQ[$];
    logic [3:0] mLvl;
    logic [3:0] mRise;
    int         mCnt[4];

    task automatic modelClear();
        rawQ.delete();
        rawQ.push_back(4'b0);
        rawQ.push_back(4'b0);
        synQ.delete();
        mLvl  = 4'b0;
        mRise = 4'b0;
        for (int i = 0; i < 4; i++) mCnt[i] = 0;
    endtask

    task automatic modelStep();
        logic [3:0] syn;
        logic [3:0] newRise;
        bit         allDiffer;
        if (!rst_n) begin
            modelClear();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (green[i]) mCnt[i] = 0;
            else if (mRise[i] && mCnt[i] < CMAX) mCnt[i] = mCnt[i] + 1;
        end
        rawQ.push_back(raw_det);
        syn = rawQ.pop_front();
        synQ.push_back(syn);
        if (synQ.size() > DEB) void'(synQ.pop_front());
        newRise = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (synQ.size() == DEB) begin
                allDiffer = 1'b1;
                foreach (synQ[j]) if (synQ[j][i] == mLvl[i]) allDiffer = 1'b0;
                if (allDiffer) begin
                    newRise[i] = ~mLvl[i];
                    mLvl[i]    = ~mLvl[i];
                end
            end
        end
        mRise = newRise;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] g);
        raw_det = r;
        green   = g;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expQ,
                               input logic [3:0] expSs, input logic [3:0] expFs);
        checks++;
        if (q_cnt !== expQ || ss !== expSs || fs !== expFs) begin
            failures++;
            $display("[TB] FAIL %s: got q_cnt=%h ss=%b fs=%b, expected q_cnt=%h ss=%b fs=%b",
                     name, q_cnt, ss, fs, expQ, expSs, expFs);
        end
    endtask

    task automatic modelCheck(input string name);
        logic [15:0] eq;
        logic [3:0]  es;
        logic [3:0]  ef;
        for (int i = 0; i < 4; i++) begin
            eq[i*4 +: 4] = 4'(mCnt[i]);
            es[i]        = (mCnt[i] != 0);
            ef[i]        = (mCnt[i] >= FULL);
        end
        checkOutput(name, eq, es, ef);
    endtask

    // One clock edge; the model sees the same inputs the DUT sampled
    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        applyStimulus(4'b0, 4'b0);
        rst_n = 1'b0;
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  raw;
        logic [3:0]  grn;
        int          hold;
        logic [15:0] q;
        logic [3:0]  s;
        logic [3:0]  f;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        int          n;
        int          b;
        logic        hi;
        logic [3:0]  rr;
        logic [3:0]  gg;
        logic [15:0] eq;

        // Sequential vectors from reset: inputs, cycles held, outputs after
        vecs[0] = '{4'b0001, 4'b0000, 10, 16'h0001, 4'b0001, 4'b0000};
        vecs[1] = '{4'b0000, 4'b0000, 10, 16'h0001, 4'b0001, 4'b0000};
        vecs[2] = '{4'b0011, 4'b0000, 10, 16'h0012, 4'b0011, 4'b0000};
        vecs[3] = '{4'b0000, 4'b0000, 10, 16'h0012, 4'b0011, 4'b0000};
        vecs[4] = '{4'b0000, 4'b0001,  1, 16'h0010, 4'b0010, 4'b0000};
        vecs[5] = '{4'b0100, 4'b0000,  2, 16'h0010, 4'b0010, 4'b0000};
        vecs[6] = '{4'b0000, 4'b0000, 10, 16'h0010, 4'b0010, 4'b0000};
        vecs[7] = '{4'b1111, 4'b0000, 10, 16'h1121, 4'b1111, 4'b0000};
        vecs[8] = '{4'b0000, 4'b1111,  1, 16'h0000, 4'b0000, 4'b0000};
        vecs[9] = '{4'b1000, 4'b1000, 10, 16'h0000, 4'b0000, 4'b0000};

        doReset();
        checkOutput("reset_state", 16'h0, 4'b0, 4'b0);

        for (int v = 0; v < NV; v++) begin
            applyStimulus(vecs[v].raw, vecs[v].grn);
            repeat (vecs[v].hold) tick();
            checkOutput($sformatf("vec%0d", v), vecs[v].q, vecs[v].s, vecs[v].f);
        end

        // Arrival latency on lane T2 with T1 green: count appears at edge 7
        doReset();
        applyStimulus(4'b0010, 4'b0001);
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t >= 7) checkOutput($sformatf("latency_t%0d", t), 16'h0010, 4'b0010, 4'b0);
            else        checkOutput($sformatf("latency_t%0d", t), 16'h0000, 4'b0000, 4'b0);
        end

        // Three-cycle glitch on lane T3 must be ignored
        doReset();
        applyStimulus(4'b0100, 4'b0000);
        for (int t = 1; t <= 3; t++) begin
            tick();
            checkOutput($sformatf("glitch_hi%0d", t), 16'h0, 4'b0, 4'b0);
        end
        applyStimulus(4'b0000, 4'b0000);
        for (int t = 1; t <= 10; t++) begin
            tick();
            checkOutput($sformatf("glitch_lo%0d", t), 16'h0, 4'b0, 4'b0);
        end

        // 20 pulses on lane T4 (6 high / 6 low); pulse j counts at edge 12j+7
        doReset();
        for (int t = 1; t <= 240; t++) begin
            hi = (((t - 1) % 12) < 6);
            applyStimulus({hi, 3'b000}, 4'b0000);
            tick();
            n = (t >= 7) ? ((t - 7) / 12 + 1) : 0;
            if (n > CMAX) n = CMAX;
            eq = 16'(n) << (T4 * 4);
            checkOutput($sformatf("full_t%0d", t), eq, {n != 0, 3'b000}, {n >= FULL, 3'b000});
        end
        applyStimulus(4'b0000, 4'b0000);
        repeat (12) tick();
        checkOutput("saturate_hold", 16'hF000, 4'b1000, 4'b1000);

        // Five arrivals on lane T3, then green empties it and blocks more
        doReset();
        for (int t = 1; t <= 60; t++) begin
            hi = (((t - 1) % 12) < 6);
            applyStimulus({1'b0, hi, 2'b00}, 4'b0000);
            tick();
        end
        checkOutput("lane2_five", 16'h0500, 4'b0100, 4'b0000);
        applyStimulus(4'b0000, 4'b0100);
        tick();
        checkOutput("lane2_green_clear", 16'h0, 4'b0, 4'b0);
        for (int t = 1; t <= 36; t++) begin
            hi = (((t - 1) % 12) < 6);
            applyStimulus({1'b0, hi, 2'b00}, 4'b0100);
            tick();
            checkOutput($sformatf("lane2_green_t%0d", t), 16'h0, 4'b0, 4'b0);
        end

        // Asynchronous reset mid-debounce with non-zero counts
        doReset();
        applyStimulus(4'b1111, 4'b0000);
        repeat (20) tick();
        checkOutput("pre_reset_counts", 16'h1111, 4'b1111, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 16'h0, 4'b0, 4'b0);
        modelClear();
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b0010, 4'b0000);
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t >= 7) checkOutput($sformatf("post_reset_t%0d", t), 16'h0010, 4'b0010, 4'b0);
            else        checkOutput($sformatf("post_reset_t%0d", t), 16'h0000, 4'b0000, 4'b0);
        end

        // Arrival event on T1 coinciding with green on T1 is discarded
        doReset();
        applyStimulus(4'b0001, 4'b0000);
        repeat (6) tick();
        checkOutput("coincide_pre", 16'h0, 4'b0, 4'b0);
        applyStimulus(4'b0001, 4'b0001);
        tick();
        checkOutput("coincide_edge", 16'h0, 4'b0, 4'b0);
        applyStimulus(4'b0001, 4'b0000);
        repeat (4) tick();
        checkOutput("coincide_after", 16'h0, 4'b0, 4'b0);

        // Randomized traffic against the behavioural model
        doReset();
        rr = 4'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = int'($urandom_range(0, 3));
                rr[b] = ~rr[b];
            end
            gg = 4'b0;
            if ($urandom_range(0, 79) == 0) gg = 4'(1 << $urandom_range(0, 3));
            else if ($urandom_range(0, 299) == 0) gg = 4'($urandom_range(0, 15));
            applyStimulus(rr, gg);
            tick();
            modelCheck($sformatf("random%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
